// File: rtl/rest4_serie.sv
// rest4_serie: bit-serial subtractor, D = A - B - b_in, one bit per cycle, LSB first.
// Latency WIDTH cycles from accept to the done pulse; one operation per WIDTH+1 cycles.
// A start while busy is dropped (no queuing); the result and flags hold between completions.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   start, A, B, b_in  request and operands, sampled on the accepting edge
//   busy, done         busy while bits are being processed, done is a one-cycle pulse
//   D, b_out, ovf, zero  registered difference, final borrow, signed overflow, D==0
module rest4_serie #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             b_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] D,
   output logic             b_out,
   output logic             ovf,
   output logic             zero
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] sh_a;
   logic [WIDTH-1:0] sh_b;
   logic [WIDTH-1:0] res;
   logic             br;
   logic [CW-1:0]    cnt;
   logic             a_msb;
   logic             b_msb;

   // single full-subtractor cell on the LSBs of the shift registers
   logic             a_bit;
   logic             b_bit;
   logic             d_bit;
   logic             br_nxt;
   logic [WIDTH-1:0] res_nxt;
   logic             accept;

   always_comb begin
      a_bit   = sh_a[0];
      b_bit   = sh_b[0];
      d_bit   = a_bit ^ b_bit ^ br;
      br_nxt  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
      // new bit enters at the MSB; after WIDTH shifts bit 0 lands at position 0
      res_nxt = {d_bit, res[WIDTH-1:1]};
   end

   // The closing edge of the DONE cycle is the first IDLE sampling point, so a
   // held start is taken there; this gives the WIDTH+1 cycle throughput.
   assign accept = start && (state == S_IDLE || state == S_DONE);

   assign busy = (state == S_BUSY);
   assign done = (state == S_DONE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         sh_a  <= '0;
         sh_b  <= '0;
         res   <= '0;
         br    <= 1'b0;
         cnt   <= '0;
         a_msb <= 1'b0;
         b_msb <= 1'b0;
         D     <= '0;
         b_out <= 1'b0;
         ovf   <= 1'b0;
         zero  <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (accept) begin
                  sh_a  <= A;
                  sh_b  <= B;
                  br    <= b_in;
                  cnt   <= '0;
                  a_msb <= A[WIDTH-1];
                  b_msb <= B[WIDTH-1];
                  state <= S_BUSY;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_BUSY: begin
               sh_a <= sh_a >> 1;
               sh_b <= sh_b >> 1;
               res  <= res_nxt;
               br   <= br_nxt;
               if (cnt == LAST) begin
                  // counter holds at its last value instead of wrapping
                  state <= S_DONE;
                  D     <= res_nxt;
                  b_out <= br_nxt;
                  ovf   <= (a_msb ^ b_msb) & (res_nxt[WIDTH-1] ^ a_msb);
                  zero  <= (res_nxt == '0);
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rest4_serie.sv
// tb_rest4_serie: bench for the bit-serial subtractor rest4_serie (WIDTH=4).
// Expected results are queued when an operation is issued and popped on done.
// Directed vectors carry hand-computed results; random runs use a signed-arithmetic model.
module tb_rest4_serie;

   localparam int W = 4;

   typedef struct packed {
      logic [W-1:0] d;
      logic         bo;
      logic         ov;
      logic         z;
   } res_t;

   typedef struct packed {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         bi;
      res_t         r;
   } vec_t;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         b_in;
   logic         busy;
   logic         done;
   logic [W-1:0] D;
   logic         b_out;
   logic         ovf;
   logic         zero;

   int   n_cmp = 0;
   int   n_err = 0;
   res_t exp_q[$];

   rest4_serie #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .A(A), .B(B), .b_in(b_in),
      .busy(busy), .done(done), .D(D), .b_out(b_out), .ovf(ovf), .zero(zero)
   );

   always #5 clk = ~clk;

   function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
      res_t r;
      int   ua, ub, sa, sb, udiff, sdiff;
      ua    = int'(a);
      ub    = int'(b);
      sa    = (a[W-1]) ? ua - (1 << W) : ua;
      sb    = (b[W-1]) ? ub - (1 << W) : ub;
      udiff = ua - ub - int'(bi);
      sdiff = sa - sb - int'(bi);
      r.d   = W'(udiff + (1 << W));
      r.bo  = (udiff < 0);
      r.ov  = (sdiff < -(1 << (W - 1))) || (sdiff > (1 << (W - 1)) - 1);
      r.z   = (r.d == '0);
      return r;
   endfunction

   // pulse start for one accepting edge; returns at the negedge after the accept
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
      A = a; B = b; b_in = bi; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // bounded wait for done; cyc is the number of negedges waited
   task automatic wait_done(output int cyc);
      cyc = 0;
      while (done !== 1'b1 && cyc < 30) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; A = '0; B = '0; b_in = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      n_cmp++; if (busy  !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
      n_cmp++; if (done  !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
      n_cmp++; if (D     !== '0)   begin n_err++; $display("FAIL reset_D got=%b exp=0000", D); end
      n_cmp++; if (b_out !== 1'b0) begin n_err++; $display("FAIL reset_b_out got=%b exp=0", b_out); end
      n_cmp++; if (ovf   !== 1'b0) begin n_err++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
      n_cmp++; if (zero  !== 1'b0) begin n_err++; $display("FAIL reset_zero got=%b exp=0", zero); end
   endtask

   task automatic test_directed();
      vec_t tbl[5];
      res_t got, e;
      int   cyc;
      //            A        B        bin   D        bo    ov    z
      tbl[0] = {4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0};
      tbl[1] = {4'b1111, 4'b0001, 1'b0, 4'b1110, 1'b0, 1'b0, 1'b0};
      tbl[2] = {4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0};
      tbl[3] = {4'b0101, 4'b1010, 1'b0, 4'b1011, 1'b1, 1'b1, 1'b0};
      tbl[4] = {4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b1, 1'b0};
      foreach (tbl[i]) begin
         exp_q.push_back(tbl[i].r);
         issue(tbl[i].a, tbl[i].b, tbl[i].bi);
         n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL dir%0d_busy got=%b exp=1", i, busy); end
         wait_done(cyc);
         n_cmp++; if (cyc !== W) begin n_err++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, cyc, W); end
         if (done === 1'b1) begin
            got = {D, b_out, ovf, zero};
            e   = exp_q.pop_front();
            n_cmp++; if (got !== e) begin n_err++; $display("FAIL dir%0d_result got=%b exp=%b", i, got, e); end
            n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL dir%0d_busy_with_done got=%b exp=0", i, busy); end
         end
         @(negedge clk);
         n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL dir%0d_done_pulse got=%b exp=0", i, done); end
      end
   endtask

   task automatic test_ignore_start();
      res_t prev, got, e;
      int   pulses, overlap;
      prev = {D, b_out, ovf, zero};
      exp_q.push_back({4'b0000, 1'b0, 1'b0, 1'b1});
      issue(4'b0111, 4'b0111, 1'b0);
      @(negedge clk);                       // BUSY cycle 2
      A = 4'b1111; B = 4'b0000; b_in = 1'b1; start = 1'b1;
      @(negedge clk);                       // BUSY cycle 3
      got = {D, b_out, ovf, zero};
      n_cmp++; if (got !== prev) begin n_err++; $display("FAIL hold_in_busy got=%b exp=%b", got, prev); end
      @(negedge clk);
      start = 1'b0;
      pulses = 0; overlap = 0;
      for (int k = 0; k < 12; k++) begin
         if (done === 1'b1) begin
            pulses++;
            if (pulses == 1) begin
               got = {D, b_out, ovf, zero};
               e   = exp_q.pop_front();
               n_cmp++; if (got !== e) begin n_err++; $display("FAIL ignore_result got=%b exp=%b", got, e); end
            end
         end
         if (busy === 1'b1 && done === 1'b1) overlap++;
         @(negedge clk);
      end
      n_cmp++; if (pulses !== 1)  begin n_err++; $display("FAIL ignore_pulses got=%0d exp=1", pulses); end
      n_cmp++; if (overlap !== 0) begin n_err++; $display("FAIL busy_done_overlap got=%0d exp=0", overlap); end
   endtask

   task automatic test_reset_mid();
      res_t got, e;
      int   cyc;
      issue(4'b0000, 4'b1111, 1'b0);
      @(negedge clk);                       // BUSY cycle 2
      reset = 1'b1;
      @(negedge clk);
      got = {D, b_out, ovf, zero};
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got=%b exp=0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL midrst_done got=%b exp=0", done); end
      n_cmp++; if (got !== '0)    begin n_err++; $display("FAIL midrst_outputs got=%b exp=0000000", got); end
      A = 4'b0101; B = 4'b0001; b_in = 1'b0; start = 1'b1;  // start together with reset
      @(negedge clk);
      reset = 1'b0; start = 1'b0;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL start_in_reset got=%b exp=0", busy); end
      @(negedge clk);
      exp_q.push_back({4'b0000, 1'b1, 1'b0, 1'b1});
      issue(4'b0000, 4'b1111, 1'b1);
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL postrst_busy got=%b exp=1", busy); end
      wait_done(cyc);
      n_cmp++; if (cyc !== W) begin n_err++; $display("FAIL postrst_latency got=%0d exp=%0d", cyc, W); end
      if (done === 1'b1) begin
         got = {D, b_out, ovf, zero};
         e   = exp_q.pop_front();
         n_cmp++; if (got !== e) begin n_err++; $display("FAIL postrst_result got=%b exp=%b", got, e); end
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] a, b;
      logic         bi;
      res_t         got, e;
      int           cyc;
      a = W'($urandom_range(0, 2**W - 1)); b = W'($urandom_range(0, 2**W - 1)); bi = 1'($urandom_range(0, 1));
      exp_q.push_back(model(a, b, bi));
      A = a; B = b; b_in = bi; start = 1'b1;
      @(negedge clk);                       // first accept done
      for (int k = 0; k < 10; k++) begin
         if (k < 9) begin
            a = W'($urandom_range(0, 2**W - 1)); b = W'($urandom_range(0, 2**W - 1)); bi = 1'($urandom_range(0, 1));
            exp_q.push_back(model(a, b, bi));
            A = a; B = b; b_in = bi;
         end else begin
            start = 1'b0;
         end
         wait_done(cyc);
         n_cmp++; if (cyc !== W) begin n_err++; $display("FAIL b2b%0d_latency got=%0d exp=%0d", k, cyc, W); end
         if (done === 1'b1) begin
            got = {D, b_out, ovf, zero};
            e   = exp_q.pop_front();
            n_cmp++; if (got !== e) begin n_err++; $display("FAIL b2b%0d_result got=%b exp=%b", k, got, e); end
         end
         @(negedge clk);
         if (k < 9) begin
            // the DONE cycle's closing edge must take the held start
            n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b%0d_reaccept got=%b exp=1", k, busy); end
         end
      end
      n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL queue_drained got=%0d exp=0", exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
